// File: rtl/gsim_pkg.sv
// Shared types and constants for the banded Gauss-Seidel solver (gsim_param).
// Coefficients describe the fixed heptadiagonal matrix; RECIP approximates 1/DIAG in Q0.16.
package gsim_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_OUT
  } state_e;

  localparam int FRAC     = 16;
  localparam int C1       = 13;
  localparam int C2       = 6;
  localparam int C3       = 1;
  localparam int DIAG     = 20;
  localparam int RECIP_SH = 16;
  localparam int RECIP    = ((1 << RECIP_SH) + DIAG / 2) / DIAG;

  // Clamp v to the signed range of a w-bit value; caller truncates to w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/gsim_row_pe.sv
// Single-row Gauss-Seidel update: x_new = sat(((b<<16) + band sum) * RECIP >>> RECIP_SH).
// Purely combinational; the sum is held at X_W+8 bits signed.
module gsim_row_pe
  import gsim_pkg::*;
#(
  parameter int B_W = 16,
  parameter int X_W = 32
) (
  input  logic signed [B_W-1:0] b_i,
  input  logic signed [X_W-1:0] xm1_i,
  input  logic signed [X_W-1:0] xm2_i,
  input  logic signed [X_W-1:0] xm3_i,
  input  logic signed [X_W-1:0] xp1_i,
  input  logic signed [X_W-1:0] xp2_i,
  input  logic signed [X_W-1:0] xp3_i,
  output logic signed [X_W-1:0] x_new_o
);

  localparam int S_W = X_W + 8;

  logic signed [S_W-1:0] b_e;
  logic signed [S_W-1:0] n1;
  logic signed [S_W-1:0] n2;
  logic signed [S_W-1:0] n3;
  logic signed [S_W-1:0] s;
  logic signed [63:0]    prod;
  logic signed [63:0]    sat;

  always_comb begin
    b_e  = S_W'(b_i);
    n1   = S_W'(xm1_i) + S_W'(xp1_i);
    n2   = S_W'(xm2_i) + S_W'(xp2_i);
    n3   = S_W'(xm3_i) + S_W'(xp3_i);
    s    = (b_e <<< FRAC) + S_W'(C1) * n1 - S_W'(C2) * n2 + S_W'(C3) * n3;
    // Arithmetic shift floors toward minus infinity, matching the reference rounding.
    prod = (64'(s) * 64'(RECIP)) >>> RECIP_SH;
    sat  = saturate(prod, X_W);
    x_new_o = X_W'(sat);
  end

endmodule

// File: rtl/gsim_param.sv
// Parametrised N-row banded Gauss-Seidel solver: stream b in, run sweeps, stream Q16.16 x out.
// Optional early exit on convergence when GSIM_CONV_EN is defined.
module gsim_param
  import gsim_pkg::*;
#(
  parameter int N      = 16,
  parameter int B_W    = 16,
  parameter int X_W    = 32,
  parameter int ITER_W = 8
`ifdef GSIM_CONV_EN
  , parameter logic [31:0] TOL = 32'd16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [B_W-1:0]    b_in,
  input  logic        [ITER_W-1:0] iter_num,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [X_W-1:0]    x_out,
  output logic                     out_last,
  output logic                     busy,
  output logic        [ITER_W-1:0] iter_used
);

  localparam int              IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        row_q, row_d;
  logic [ITER_W-1:0]       sweep_q, sweep_d;
  logic [ITER_W-1:0]       iter_q, iter_d;
  logic [ITER_W-1:0]       used_q, used_d;
  logic [ITER_W-1:0]       sweep_inc;
  logic signed [B_W-1:0]   b_q [N];
  logic signed [X_W-1:0]   x_q [N];
  logic signed [X_W-1:0]   nb  [6];
  logic signed [X_W-1:0]   x_new;
  logic                    converged;

  // Lower neighbours already hold this sweep's values, which makes this Gauss-Seidel.
  always_comb begin
    nb = '{default: '0};
    for (int k = 1; k <= 3; k++) begin
      nb[k-1] = (int'(row_q) >= k)    ? x_q[row_q - IDX_W'(k)] : '0;
      nb[k+2] = (int'(row_q) + k < N) ? x_q[row_q + IDX_W'(k)] : '0;
    end
  end

  gsim_row_pe #(
    .B_W (B_W),
    .X_W (X_W)
  ) u_pe (
    .b_i     (b_q[row_q]),
    .xm1_i   (nb[0]),
    .xm2_i   (nb[1]),
    .xm3_i   (nb[2]),
    .xp1_i   (nb[3]),
    .xp2_i   (nb[4]),
    .xp3_i   (nb[5]),
    .x_new_o (x_new)
  );

  assign sweep_inc = sweep_q + ITER_W'(1);

`ifdef GSIM_CONV_EN
  logic        [X_W:0] dmax_q, dmax_d;
  logic        [X_W:0] delta;
  logic        [X_W:0] sweep_max;
  logic signed [X_W:0] diff;

  always_comb begin
    diff      = (X_W+1)'(x_new) - (X_W+1)'(x_q[row_q]);
    delta     = diff[X_W] ? $unsigned(-diff) : $unsigned(diff);
    sweep_max = (delta > dmax_q) ? delta : dmax_q;
    converged = (sweep_max <= (X_W+1)'(TOL));
    dmax_d    = '0;
    if (state_q == S_CALC && row_q != LAST) dmax_d = sweep_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dmax_q <= '0;
    else        dmax_q <= dmax_d;
  end
`else
  assign converged = 1'b0;
`endif

  // NOTE: every output and next-state value gets a default first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    sweep_d   = sweep_q;
    iter_d    = iter_q;
    used_d    = used_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    x_out     = '0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          iter_d  = (iter_num == '0) ? ITER_W'(1) : iter_num;
          row_d   = IDX_W'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (row_q == LAST) begin
            row_d   = '0;
            sweep_d = '0;
            state_d = S_CALC;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
      end
      S_CALC: begin
        if (row_q == LAST) begin
          row_d = '0;
          if (sweep_inc == iter_q || converged) begin
            used_d  = sweep_inc;
            state_d = S_OUT;
          end else begin
            sweep_d = sweep_inc;
          end
        end else begin
          row_d = row_q + IDX_W'(1);
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        x_out     = x_q[row_q];
        out_last  = (row_q == LAST);
        if (out_ready) begin
          if (row_q == LAST) begin
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      sweep_q <= '0;
      iter_q  <= '0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      sweep_q <= sweep_d;
      iter_q  <= iter_d;
      used_q  <= used_d;
    end
  end

  // NOTE: the b and x arrays are reset because a reset must leave no stale solution behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      if (in_valid && in_ready) b_q[row_q] <= b_in;
      if (state_q == S_IDLE && in_valid) begin
        for (int i = 0; i < N; i++) x_q[i] <= '0;
      end else if (state_q == S_CALC) begin
        x_q[row_q] <= x_new;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign iter_used = used_q;

endmodule

// File: tb/tb_gsim_param.sv
// Randomised bench for gsim_param against an arithmetic Gauss-Seidel reference model.
// Build with GSIM_CONV_EN defined to exercise early convergence.
module tb_gsim_param;

  localparam int N      = 16;
  localparam int B_W    = 16;
  localparam int X_W    = 32;
  localparam int ITER_W = 8;
  localparam int TOL_M  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [B_W-1:0]    b_in;
  logic        [ITER_W-1:0] iter_num;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [X_W-1:0]    x_out;
  logic                     out_last;
  logic                     busy;
  logic        [ITER_W-1:0] iter_used;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;
  int     hs_cyc   = 0;
  int     used_ref = 0;
  longint b_vec [N];
  longint x_ref [N];
  longint got_x [N];

  gsim_param #(
    .N      (N),
    .B_W    (B_W),
    .X_W    (X_W),
    .ITER_W (ITER_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b_in      (b_in),
    .iter_num  (iter_num),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .out_last  (out_last),
    .busy      (busy),
    .iter_used (iter_used)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // x_i <- (b_i - sum_j a_ij x_j) / 20 in Q16.16, approximated by *3277 >> 16 with floor.
  task automatic model(input int iter);
    longint x [N];
    longint s, xn, d, dmax, coef;
    int     sweeps;
    sweeps   = (iter == 0) ? 1 : iter;
    used_ref = sweeps;
    foreach (x[i]) x[i] = 0;
    for (int sw = 0; sw < sweeps; sw++) begin
      dmax = 0;
      for (int r = 0; r < N; r++) begin
        s = b_vec[r] * 65536;
        for (int k = 1; k <= 3; k++) begin
          coef = (k == 1) ? 13 : (k == 2) ? -6 : 1;
          if (r - k >= 0) s += coef * x[r-k];
          if (r + k < N)  s += coef * x[r+k];
        end
        xn = (s * 3277) >>> 16;
        if (xn > 64'sd2147483647)  xn = 64'sd2147483647;
        if (xn < -64'sd2147483648) xn = -64'sd2147483648;
        d = (xn > x[r]) ? xn - x[r] : x[r] - xn;
        if (d > dmax) dmax = d;
        x[r] = xn;
      end
`ifdef GSIM_CONV_EN
      if (dmax <= TOL_M) begin
        used_ref = sw + 1;
        break;
      end
`endif
    end
    foreach (x[i]) x_ref[i] = x[i];
  endtask

  task automatic send(input int iter, input bit gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < N && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        b_in     = B_W'(b_vec[i]);
        iter_num = (i == 0) ? ITER_W'(iter) : ITER_W'($urandom);
        if (in_ready) i++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hs_cyc   = cyc;
    check("load_done", i, N);
  endtask

  task automatic collect(input bit stalls, input int lat_exp);
    int                    guard;
    int                    beat;
    bit                    prev_stall;
    logic signed [X_W-1:0] held_x;
    logic                  held_last;
    guard = 0;
    beat = 0;
    prev_stall = 1'b0;
    held_x = '0;
    held_last = 1'b0;
    @(negedge clk);
    while (!out_valid && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid_seen", out_valid, 1);
    if (!out_valid) return;
    if (lat_exp >= 0) check("calc_cycles", cyc - hs_cyc, lat_exp);
    check("iter_used", iter_used, used_ref);
    check("busy_out", busy, 1);
    while (beat < N && guard < 20000) begin
      if (!out_valid) begin
        check("valid_gap", out_valid, 1);
        break;
      end
      if (prev_stall) begin
        check("hold_x", x_out, held_x);
        check("hold_last", out_last, held_last);
      end
      out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_ready) begin
        check($sformatf("x[%0d]", beat), x_out, x_ref[beat]);
        check("out_last", out_last, beat == N - 1);
        got_x[beat] = x_out;
        beat++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        held_x     = x_out;
        held_last  = out_last;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check("beats", beat, N);
    check("done_valid_low", out_valid, 0);
    check("done_in_ready", in_ready, 1);
  endtask

  task automatic rand_b();
    foreach (b_vec[i]) b_vec[i] = longint'(int'($urandom_range(0, 4000)) - 2000);
  endtask

  task automatic run(input int iter, input bit gaps, input bit stalls, input int lat_exp);
    model(iter);
    send(iter, gaps);
    collect(stalls, lat_exp);
  endtask

  initial begin
    int bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    b_in      = '0;
    iter_num  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_iter_used", iter_used, 0);
    check("rst_x_out", x_out, 0);

    // Unit impulse, one sweep: known first two results.
    foreach (b_vec[i]) b_vec[i] = 0;
    b_vec[0] = 20;
    run(1, 1'b0, 1'b0, 1 * N);
    check("x0_const", got_x[0], 64'h0001_0004);
    check("x1_const", got_x[1], 64'h0000_A66B);

    // All-zero b, 80 sweeps, with a stray in_valid while computing.
    foreach (b_vec[i]) b_vec[i] = 0;
    model(80);
    send(80, 1'b0);
    in_valid = 1'b1;
    b_in     = 16'sh7fff;
    @(negedge clk);
    check("calc_in_ready", in_ready, 0);
    check("calc_busy", busy, 1);
    in_valid = 1'b0;
    collect(1'b0, 80 * N);

    // Random problems with input gaps and output stalls.
    repeat (3) begin
      rand_b();
      run(80, 1'b1, 1'b1, 80 * N);
    end

    // Zero sweep count behaves as one sweep.
    rand_b();
    run(0, 1'b1, 1'b1, N);

    // Reset in the middle of sweep 5, then a fresh problem.
    rand_b();
    send(80, 1'b1);
    repeat (5 * N + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_iter_used", iter_used, 0);
    check("abort_x_out", x_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy) bad++;
    end
    check("no_partial_out", bad, 0);
    rand_b();
    run(80, 1'b1, 1'b1, 80 * N);

    // Constant b with the maximum sweep budget (early exit only with GSIM_CONV_EN).
    foreach (b_vec[i]) b_vec[i] = 100;
    run(255, 1'b0, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
